peak_finder: RTL and testbench
==============================

Name: peak_finder

Overview:
- Downstream consumer of one filter output bus (e.g. output_data_v1) in the filter test design.
- Detects pulses in the filtered stream and extracts, per pulse:
  - peak amplitude
  - peak timestamp
  - width above threshold
- Emits one result per pulse with a single-cycle valid strobe, for the later readout/histogram stage.

Parameters:
- THRESHOLD, 100: signed arm level; a pulse starts when sample > THRESHOLD.
- HYSTERESIS, 16: pulse ends when sample < THRESHOLD-HYSTERESIS. Must satisfy 0 <= HYSTERESIS < THRESHOLD; elaboration error otherwise.
- DEAD_TIME, 4: cycles ignored after each result; 0 allowed.
- SIZE_TIME, 16: timestamp counter width.
- SIZE_WIDTH, 8: pulse-width counter width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- input_data  input  SIZE_FILTER_DATA  filter output, signed two's complement
- peak_amp  output  SIZE_FILTER_DATA  maximum sample of last pulse (signed)
- peak_time  output  SIZE_TIME  timestamp of that maximum
- pulse_width  output  SIZE_WIDTH  samples in pulse
- width_sat  output  1  pulse_width saturated / forced end
- peak_valid  output  1  one-cycle strobe, results valid
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, state IDLE, timestamp 0, sample register 0.
  - Reset mid-pulse discards the pulse; no peak_valid is issued.
- Timestamp: free-running SIZE_TIME counter, +1 every clk, wraps 2^SIZE_TIME-1 -> 0.
- Input pipeline:
  - input_data is registered into x together with ts_x (the counter value at that edge).
  - All decisions use x; comparisons are signed.
- FSM:
  - IDLE: if x > THRESHOLD -> TRACK. Load max=x, tmax=ts_x, width=1.
  - TRACK, while x >= THRESHOLD-HYSTERESIS:
    - if x > max: max=x, tmax=ts_x. Equal values keep the first occurrence.
    - width += 1.
  - TRACK end conditions:
    - if x < THRESHOLD-HYSTERESIS: emit, width_sat=0. The ending sample is not counted.
    - if the width counter reaches 2^SIZE_WIDTH-1 and the pulse continues: emit with width_sat=1, pulse_width=all-ones.
    - Next state after emit: DEAD, or WAIT_LOW if forced.
  - Emit: peak_amp/peak_time/pulse_width/width_sat registered; peak_valid=1 for exactly one cycle.
    - Outputs hold until the next emit.
  - DEAD: counts DEAD_TIME cycles ignoring x, then -> WAIT_LOW.
    - DEAD_TIME=0 skips directly to WAIT_LOW.
  - WAIT_LOW: -> IDLE on the first x < THRESHOLD-HYSTERESIS. The same cycle cannot re-arm.
    - Guarantees no re-trigger on a saturated/long pulse.
- Latency: input_data falling below the low level at edge k -> x at edge k -> peak_valid high after edge k+1 (one cycle).
- busy=1 in TRACK, DEAD, WAIT_LOW.
- Width/time arithmetic:
  - unsigned, no overflow except the saturation rule above.
  - peak_time may wrap; the consumer handles it.
- x exactly equal to THRESHOLD does not arm; x exactly equal to THRESHOLD-HYSTERESIS does not end.

Decomposition:
- package_settings gains:
  - SIZE_TIME and SIZE_WIDTH constants
  - typedef enum logic [2:0] {IDLE, TRACK, DEAD, WAIT_LOW} peak_state_t
  - typedef logic signed [SIZE_FILTER_DATA-1:0] filter_sample_t
- SIZE_FILTER_DATA is reused from package_settings.
- No sub-module; timestamp counter and FSM stay in peak_finder.
- Top-level instantiates one peak_finder per enabled filter.

Test Plan:
- Triangle (THR=100, HYST=16, DEAD=4): input_data 0,50,120,200,300,250,150,80,0 on consecutive cycles, sample 300 latched at ts=5 -> one peak_valid, peak_amp=300, peak_time=5, pulse_width=5, width_sat=0.
- Hysteresis: 0,150,90,150,0 -> 90 does not end the pulse -> single result: peak_amp=150, peak_time = ts of first 150, pulse_width=3.
- Below/at threshold: constant 100 or 99 for 50 cycles -> no peak_valid, busy=0. Negative input -200 -> no trigger.
- Saturation (SIZE_WIDTH=8): 300 held for 400 cycles -> peak_valid once, pulse_width=255, width_sat=1. No second result until input drops below 84 and then rises above 100 again.
- Dead time: second pulse 200 starting 2 cycles after the first result's peak_valid -> ignored (no second strobe). Same pulse starting 6 cycles after -> detected.
- Reset mid-TRACK at peak 250 -> outputs 0 immediately, no peak_valid. After release, the next pulse 0,180,0 -> peak_amp=180, pulse_width=1.

Source files
------------

// File: rtl/package_settings.sv
// rtl/package_settings.sv - shared widths and types for the filter test design
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;
  localparam int SIZE_TIME        = 16;
  localparam int SIZE_WIDTH       = 8;

  typedef enum logic [2:0] {IDLE, TRACK, DEAD, WAIT_LOW} peak_state_t;

  typedef logic signed [SIZE_FILTER_DATA-1:0] filter_sample_t;

endpackage

// File: rtl/peak_finder.sv
// rtl/peak_finder.sv - pulse detector extracting peak amplitude, peak timestamp and width
// One result strobe per pulse; hysteresis, dead time and width saturation guard re-triggering.
module peak_finder
  import package_settings::*;
#(
  parameter int THRESHOLD  = 100,
  parameter int HYSTERESIS = 16,
  parameter int DEAD_TIME  = 4,
  parameter int SIZE_TIME  = package_settings::SIZE_TIME,
  parameter int SIZE_WIDTH = package_settings::SIZE_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic        [SIZE_TIME-1:0]        peak_time,
  output logic        [SIZE_WIDTH-1:0]       pulse_width,
  output logic                               width_sat,
  output logic                               peak_valid,
  output logic                               busy
);

  if (HYSTERESIS < 0 || HYSTERESIS >= THRESHOLD) begin : g_bad_hysteresis
    $error("peak_finder: HYSTERESIS must satisfy 0 <= HYSTERESIS < THRESHOLD");
  end

  localparam filter_sample_t C_THR = filter_sample_t'(THRESHOLD);
  localparam filter_sample_t C_LOW = filter_sample_t'(THRESHOLD - HYSTERESIS);
  localparam int             DW    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DW-1:0]  C_DEAD_LOAD = (DEAD_TIME > 0) ? DW'(DEAD_TIME - 1) : '0;

  logic [SIZE_TIME-1:0]  r_ts;
  logic [SIZE_TIME-1:0]  r_ts_x;
  filter_sample_t        r_x;
  peak_state_t           r_state;
  filter_sample_t        r_max;
  logic [SIZE_TIME-1:0]  r_tmax;
  logic [SIZE_WIDTH-1:0] r_width;
  logic [DW-1:0]         r_dead_cnt;
  filter_sample_t        r_peak_amp;
  logic [SIZE_TIME-1:0]  r_peak_time;
  logic [SIZE_WIDTH-1:0] r_pulse_width;
  logic                  r_width_sat;
  logic                  r_peak_valid;
  logic                  w_above;
  logic                  w_below;

  assign w_above = (r_x > C_THR);
  assign w_below = (r_x < C_LOW);

  // Sample and its timestamp travel together so tmax refers to the sample actually judged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts   <= '0;
      r_ts_x <= '0;
      r_x    <= '0;
    end else begin
      r_ts   <= r_ts + SIZE_TIME'(1);
      r_ts_x <= r_ts;
      r_x    <= input_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_max         <= '0;
      r_tmax        <= '0;
      r_width       <= '0;
      r_dead_cnt    <= '0;
      r_peak_amp    <= '0;
      r_peak_time   <= '0;
      r_pulse_width <= '0;
      r_width_sat   <= 1'b0;
      r_peak_valid  <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_above) begin
            r_state <= TRACK;
            r_max   <= r_x;
            r_tmax  <= r_ts_x;
            r_width <= SIZE_WIDTH'(1);
          end
        end
        TRACK: begin
          if (w_below) begin
            r_peak_amp    <= r_max;
            r_peak_time   <= r_tmax;
            r_pulse_width <= r_width;
            r_width_sat   <= 1'b0;
            r_peak_valid  <= 1'b1;
            r_dead_cnt    <= C_DEAD_LOAD;
            r_state       <= (DEAD_TIME == 0) ? WAIT_LOW : DEAD;
          end else if (r_width == '1) begin
            // Forced end: skip dead time and wait for the long pulse to actually drop.
            r_peak_amp    <= r_max;
            r_peak_time   <= r_tmax;
            r_pulse_width <= '1;
            r_width_sat   <= 1'b1;
            r_peak_valid  <= 1'b1;
            r_state       <= WAIT_LOW;
          end else begin
            if (r_x > r_max) begin
              r_max  <= r_x;
              r_tmax <= r_ts_x;
            end
            r_width <= r_width + SIZE_WIDTH'(1);
          end
        end
        DEAD: begin
          if (r_dead_cnt == '0) begin
            r_state <= WAIT_LOW;
          end else begin
            r_dead_cnt <= r_dead_cnt - DW'(1);
          end
        end
        WAIT_LOW: begin
          if (w_below) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign peak_amp    = r_peak_amp;
  assign peak_time   = r_peak_time;
  assign pulse_width = r_pulse_width;
  assign width_sat   = r_width_sat;
  assign peak_valid  = r_peak_valid;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_peak_finder.sv
// tb/tb_peak_finder.sv - directed self-checking bench for peak_finder
module tb_peak_finder;
  import package_settings::*;

  logic                               clk;
  logic                               reset;
  logic signed [SIZE_FILTER_DATA-1:0] input_data;
  logic signed [SIZE_FILTER_DATA-1:0] peak_amp;
  logic        [SIZE_TIME-1:0]        peak_time;
  logic        [SIZE_WIDTH-1:0]       pulse_width;
  logic                               width_sat;
  logic                               peak_valid;
  logic                               busy;

  int n_vec;
  int n_bad;
  int n_valid;
  int cyc;
  int cap_amp;
  int cap_time;
  int cap_width;
  int cap_sat;
  int cap_edge;
  int tri_v [9] = '{0, 50, 120, 200, 300, 250, 150, 80, 0};

  peak_finder dut (
    .clk        (clk),
    .reset      (reset),
    .input_data (input_data),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .pulse_width(pulse_width),
    .width_sat  (width_sat),
    .peak_valid (peak_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int v);
    input_data = SIZE_FILTER_DATA'(v);
    @(posedge clk);
    #1;
    if (peak_valid) begin
      n_valid++;
      cap_amp   = int'(peak_amp);
      cap_time  = int'(peak_time);
      cap_width = int'(pulse_width);
      cap_sat   = int'(width_sat);
      cap_edge  = cyc;
    end
    cyc++;
  endtask

  task automatic apply_reset;
    input_data = '0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    n_valid = 0;
    cyc     = 0;
  endtask

  task automatic run_triangle;
    step(0);
    for (int i = 0; i < 9; i++) step(tri_v[i]);
  endtask

  task automatic test_reset;
    apply_reset();
    reset = 1'b0;
    #1;
    n_vec++; if (peak_amp !== 0)    begin n_bad++; $display("FAIL rst_amp: got %0d expected 0", peak_amp); end
    n_vec++; if (peak_time !== 0)   begin n_bad++; $display("FAIL rst_time: got %0d expected 0", peak_time); end
    n_vec++; if (pulse_width !== 0) begin n_bad++; $display("FAIL rst_width: got %0d expected 0", pulse_width); end
    n_vec++; if (width_sat !== 0)   begin n_bad++; $display("FAIL rst_sat: got %0d expected 0", width_sat); end
    n_vec++; if (peak_valid !== 0)  begin n_bad++; $display("FAIL rst_valid: got %0d expected 0", peak_valid); end
    n_vec++; if (busy !== 0)        begin n_bad++; $display("FAIL rst_busy: got %0d expected 0", busy); end
  endtask

  task automatic test_triangle;
    apply_reset();
    run_triangle();
    repeat (8) step(0);
    n_vec++; if (n_valid !== 1)   begin n_bad++; $display("FAIL tri_count: got %0d expected 1", n_valid); end
    n_vec++; if (cap_amp !== 300) begin n_bad++; $display("FAIL tri_amp: got %0d expected 300", cap_amp); end
    n_vec++; if (cap_time !== 5)  begin n_bad++; $display("FAIL tri_time: got %0d expected 5", cap_time); end
    n_vec++; if (cap_width !== 5) begin n_bad++; $display("FAIL tri_width: got %0d expected 5", cap_width); end
    n_vec++; if (cap_sat !== 0)   begin n_bad++; $display("FAIL tri_sat: got %0d expected 0", cap_sat); end
    n_vec++; if (cap_edge !== 9)  begin n_bad++; $display("FAIL tri_latency: got edge %0d expected 9", cap_edge); end
    n_vec++; if (peak_amp !== 300) begin n_bad++; $display("FAIL tri_hold: got %0d expected 300", peak_amp); end
    n_vec++; if (busy !== 0)      begin n_bad++; $display("FAIL tri_busy_end: got %0d expected 0", busy); end
  endtask

  task automatic test_hysteresis;
    apply_reset();
    step(0);
    step(0); step(150); step(90); step(150); step(0);
    repeat (6) step(0);
    n_vec++; if (n_valid !== 1)   begin n_bad++; $display("FAIL hys_count: got %0d expected 1", n_valid); end
    n_vec++; if (cap_amp !== 150) begin n_bad++; $display("FAIL hys_amp: got %0d expected 150", cap_amp); end
    n_vec++; if (cap_time !== 2)  begin n_bad++; $display("FAIL hys_time: got %0d expected 2", cap_time); end
    n_vec++; if (cap_width !== 3) begin n_bad++; $display("FAIL hys_width: got %0d expected 3", cap_width); end
  endtask

  task automatic test_low_edge;
    apply_reset();
    step(0);
    step(0); step(150); step(84); step(84); step(150); step(0);
    repeat (6) step(0);
    n_vec++; if (n_valid !== 1)   begin n_bad++; $display("FAIL low_count: got %0d expected 1", n_valid); end
    n_vec++; if (cap_time !== 2)  begin n_bad++; $display("FAIL low_tie_time: got %0d expected 2", cap_time); end
    n_vec++; if (cap_width !== 4) begin n_bad++; $display("FAIL low_width: got %0d expected 4", cap_width); end
  endtask

  task automatic test_below;
    apply_reset();
    step(0);
    repeat (50) step(100);
    n_vec++; if (n_valid !== 0) begin n_bad++; $display("FAIL at_thr_count: got %0d expected 0", n_valid); end
    n_vec++; if (busy !== 0)    begin n_bad++; $display("FAIL at_thr_busy: got %0d expected 0", busy); end
    repeat (50) step(99);
    repeat (10) step(-200);
    n_vec++; if (n_valid !== 0) begin n_bad++; $display("FAIL below_count: got %0d expected 0", n_valid); end
    n_vec++; if (busy !== 0)    begin n_bad++; $display("FAIL below_busy: got %0d expected 0", busy); end
  endtask

  task automatic test_saturation;
    apply_reset();
    step(0);
    repeat (400) step(300);
    n_vec++; if (n_valid !== 1)     begin n_bad++; $display("FAIL sat_count: got %0d expected 1", n_valid); end
    n_vec++; if (cap_width !== 255) begin n_bad++; $display("FAIL sat_width: got %0d expected 255", cap_width); end
    n_vec++; if (cap_sat !== 1)     begin n_bad++; $display("FAIL sat_flag: got %0d expected 1", cap_sat); end
    n_vec++; if (cap_amp !== 300)   begin n_bad++; $display("FAIL sat_amp: got %0d expected 300", cap_amp); end
    n_vec++; if (cap_time !== 1)    begin n_bad++; $display("FAIL sat_time: got %0d expected 1", cap_time); end
    n_vec++; if (cap_edge !== 257)  begin n_bad++; $display("FAIL sat_edge: got %0d expected 257", cap_edge); end
    n_vec++; if (busy !== 1)        begin n_bad++; $display("FAIL sat_busy: got %0d expected 1", busy); end
    repeat (5) step(90);
    repeat (5) step(300);
    n_vec++; if (n_valid !== 1)     begin n_bad++; $display("FAIL sat_no_retrig: got %0d expected 1", n_valid); end
    step(83);
    repeat (3) step(300);
    repeat (8) step(0);
    n_vec++; if (n_valid !== 2)     begin n_bad++; $display("FAIL sat_rearm_count: got %0d expected 2", n_valid); end
    n_vec++; if (cap_width !== 3)   begin n_bad++; $display("FAIL sat_rearm_width: got %0d expected 3", cap_width); end
    n_vec++; if (cap_sat !== 0)     begin n_bad++; $display("FAIL sat_rearm_flag: got %0d expected 0", cap_sat); end
    n_vec++; if (cap_time !== 412)  begin n_bad++; $display("FAIL sat_rearm_time: got %0d expected 412", cap_time); end
  endtask

  task automatic test_dead_time;
    apply_reset();
    run_triangle();
    step(0);
    repeat (3) step(200);
    repeat (10) step(0);
    n_vec++; if (n_valid !== 1)   begin n_bad++; $display("FAIL dead_ignored: got %0d expected 1", n_valid); end
    apply_reset();
    run_triangle();
    repeat (5) step(0);
    repeat (3) step(200);
    repeat (10) step(0);
    n_vec++; if (n_valid !== 2)   begin n_bad++; $display("FAIL dead_detect: got %0d expected 2", n_valid); end
    n_vec++; if (cap_amp !== 200) begin n_bad++; $display("FAIL dead_amp: got %0d expected 200", cap_amp); end
    n_vec++; if (cap_time !== 15) begin n_bad++; $display("FAIL dead_time: got %0d expected 15", cap_time); end
    n_vec++; if (cap_width !== 3) begin n_bad++; $display("FAIL dead_width: got %0d expected 3", cap_width); end
    n_vec++; if (cap_edge !== 19) begin n_bad++; $display("FAIL dead_edge: got %0d expected 19", cap_edge); end
  endtask

  task automatic test_reset_mid_track;
    apply_reset();
    run_triangle();
    repeat (6) step(0);
    step(180);
    step(250);
    step(250);
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (peak_amp !== 0)    begin n_bad++; $display("FAIL mid_amp: got %0d expected 0", peak_amp); end
    n_vec++; if (pulse_width !== 0) begin n_bad++; $display("FAIL mid_width: got %0d expected 0", pulse_width); end
    n_vec++; if (peak_time !== 0)   begin n_bad++; $display("FAIL mid_time: got %0d expected 0", peak_time); end
    n_vec++; if (busy !== 0)        begin n_bad++; $display("FAIL mid_busy: got %0d expected 0", busy); end
    n_vec++; if (peak_valid !== 0)  begin n_bad++; $display("FAIL mid_valid: got %0d expected 0", peak_valid); end
    apply_reset();
    step(0);
    step(0); step(180); step(0);
    repeat (6) step(0);
    n_vec++; if (n_valid !== 1)   begin n_bad++; $display("FAIL mid_after_count: got %0d expected 1", n_valid); end
    n_vec++; if (cap_amp !== 180) begin n_bad++; $display("FAIL mid_after_amp: got %0d expected 180", cap_amp); end
    n_vec++; if (cap_width !== 1) begin n_bad++; $display("FAIL mid_after_width: got %0d expected 1", cap_width); end
    n_vec++; if (cap_time !== 2)  begin n_bad++; $display("FAIL mid_after_time: got %0d expected 2", cap_time); end
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    n_valid    = 0;
    cyc        = 0;
    cap_amp    = 0;
    cap_time   = 0;
    cap_width  = 0;
    cap_sat    = 0;
    cap_edge   = 0;
    reset      = 1'b0;
    input_data = '0;
    test_reset();
    test_triangle();
    test_hysteresis();
    test_low_edge();
    test_below();
    test_saturation();
    test_dead_time();
    test_reset_mid_track();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
